// File: rtl/sd_forward_pkg.sv
// Shared types for the sideband store-and-forward block.
//   sd_field_t : default 30-bit sideband record layout
//   wr_state_e : write-side packet FSM states
//   CNT_WIDTH  : width of the overflow/underflow statistics counters
package sd_forward_pkg;

  localparam int CNT_WIDTH = 32;

  typedef struct packed {
    logic [1:0] ante;
    logic [5:0] exp;
    logic [3:0] symbol;
    logic [7:0] slot;
    logic [9:0] frame;
  } sd_field_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    DISCARD
  } wr_state_e;

endpackage

// File: rtl/sd_forward_mc_if.sv
// Packet-in / record-out bus of sd_forward_mc.
//   din_*  : packet beats from the upstream parser (restart, valid, sop, eop,
//            sideband record, channel tag) and the advisory din_ready back
//   dout_* : head/next records toward the framer plus ready/repeat/drop
// slave is the forwarding block, master is whoever drives packets and
// consumes records.
interface sd_forward_mc_if
  import sd_forward_pkg::*;
#(
  parameter int SD_WIDTH   = $bits(sd_field_t),
  parameter int CHAN_WIDTH = 2
);

  logic                  din_restart;
  logic                  din_valid;
  logic                  din_sop;
  logic                  din_eop;
  logic [SD_WIDTH-1:0]   din_sd;
  logic [CHAN_WIDTH-1:0] din_chan;
  logic                  din_ready;

  logic                  dout_ready;
  logic                  dout_repeat;
  logic                  dout_drop;
  logic                  dout_valid;
  logic [SD_WIDTH-1:0]   dout_sd;
  logic [CHAN_WIDTH-1:0] dout_chan;
  logic [SD_WIDTH-1:0]   dout_sd_pre;
  logic                  dout_pre_valid;

  modport slave (
    input  din_restart, din_valid, din_sop, din_eop, din_sd, din_chan,
    input  dout_ready, dout_repeat, dout_drop,
    output din_ready,
    output dout_valid, dout_sd, dout_chan, dout_sd_pre, dout_pre_valid
  );

  modport master (
    output din_restart, din_valid, din_sop, din_eop, din_sd, din_chan,
    output dout_ready, dout_repeat, dout_drop,
    input  din_ready,
    input  dout_valid, dout_sd, dout_chan, dout_sd_pre, dout_pre_valid
  );

endinterface

// File: rtl/sd_ring_mem.sv
// DEPTH-entry register ring holding {record, channel} words.
//   clk, rst_n             : clock, async active-low reset (clears storage)
//   wr_en/wr_addr/wr_data  : single write port
//   rd_addr                : head slot; head_data and next_data are the
//                            combinational reads at rd_addr and rd_addr+1
//   wr_addr_inc/rd_addr_inc: wrapped successors of the two pointers, so the
//                            owner never has to know the wrap rule
module sd_ring_mem #(
  parameter int DEPTH      = 5,
  parameter int ADDR_WIDTH = 3,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      head_data,
  output logic [WIDTH-1:0]      next_data,
  output logic [ADDR_WIDTH-1:0] wr_addr_inc,
  output logic [ADDR_WIDTH-1:0] rd_addr_inc
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  // DEPTH need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] p);
    if (p == LAST) return '0;
    return p + 1'b1;
  endfunction

  assign wr_addr_inc = wrap_inc(wr_addr);
  assign rd_addr_inc = wrap_inc(rd_addr);

  // Storage with a single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign head_data = mem[rd_addr];
  assign next_data = mem[rd_addr_inc];

endmodule

// File: rtl/sd_forward_mc.sv
// Sideband store-and-forward: captures one record per packet (on its sop
// beat), commits it into a DEPTH-entry ring at eop, and presents head and
// next records to the framer.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : packet input, record output, ready/repeat/drop controls
//   bloc_used      : committed entries, 0..DEPTH
//   bloc_full/empty: threshold flags
//   overflow_cnt   : packets discarded because the ring was full at sop
//   underflow_cnt  : pops/drops requested while empty
module sd_forward_mc
  import sd_forward_pkg::*;
#(
  parameter int DEPTH       = 5,
  parameter int ADDR_WIDTH  = 3,
  parameter int SD_WIDTH    = $bits(sd_field_t),
  parameter int CHAN_WIDTH  = 2,
  parameter int FULL_THRES  = 0,
  parameter int EMPTY_THRES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sd_forward_mc_if.slave        bus,
  output logic [ADDR_WIDTH:0]   bloc_used,
  output logic                  bloc_full,
  output logic                  bloc_empty,
  output logic [CNT_WIDTH-1:0]  overflow_cnt,
  output logic [CNT_WIDTH-1:0]  underflow_cnt
);

  localparam int UW      = ADDR_WIDTH + 1;
  localparam int ENTRY_W = SD_WIDTH + CHAN_WIDTH;
  localparam logic [UW-1:0] DEPTH_U   = UW'(DEPTH);
  localparam logic [UW-1:0] FULL_LVL  = UW'(DEPTH - FULL_THRES);
  localparam logic [UW-1:0] EMPTY_LVL = UW'(EMPTY_THRES);

  wr_state_e             state, state_nxt;
  logic [ENTRY_W-1:0]    stage_q;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
  logic [UW-1:0]         used_q;
  logic [ENTRY_W-1:0]    wr_data, head_entry, next_entry;

  logic has_space, head_valid, pre_valid;
  logic commit, commit_direct, stage_load, overflow_hit;
  logic pop, underflow_hit;

  assign has_space  = used_q < DEPTH_U;
  assign head_valid = used_q != '0;
  assign pre_valid  = used_q > UW'(1);

  // Write-side packet FSM. A sop beat is judged as if in IDLE whatever the
  // current state, which silently abandons a truncated packet. Admission
  // uses the registered count, so a same-cycle pop never makes room.
  always_comb begin
    state_nxt     = state;
    commit        = 1'b0;
    commit_direct = 1'b0;
    stage_load    = 1'b0;
    overflow_hit  = 1'b0;
    if (bus.din_valid && bus.din_sop) begin
      if (has_space) begin
        if (bus.din_eop) begin
          commit        = 1'b1;
          commit_direct = 1'b1;
          state_nxt     = IDLE;
        end else begin
          stage_load = 1'b1;
          state_nxt  = ACCEPT;
        end
      end else if (bus.din_eop) begin
        overflow_hit = 1'b1;
        state_nxt    = IDLE;
      end else begin
        state_nxt = DISCARD;
      end
    end else if (bus.din_valid && bus.din_eop) begin
      case (state)
        ACCEPT: begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
        DISCARD: begin
          overflow_hit = 1'b1;
          state_nxt    = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Drop wins over ready; ready with repeat holds the head in place.
  assign pop = head_valid &&
               (bus.dout_drop || (bus.dout_ready && !bus.dout_repeat));
  assign underflow_hit = !head_valid && (bus.dout_ready || bus.dout_drop);

  // Single-beat packets bypass the staging register.
  assign wr_data = commit_direct ? {bus.din_sd, bus.din_chan} : stage_q;

  // FSM state register; restart forces IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               state <= IDLE;
    else if (bus.din_restart) state <= IDLE;
    else                      state <= state_nxt;
  end

  // Staging register for the record captured on the sop beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          stage_q <= '0;
    else if (stage_load) stage_q <= {bus.din_sd, bus.din_chan};
  end

  // Pointers and occupancy; restart empties the ring and overrides any
  // commit or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used_q <= '0;
    end else if (bus.din_restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used_q <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr_inc;
      if (pop)    rd_ptr <= rd_ptr_inc;
      case ({commit, pop})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

  // Statistics; they survive a restart, and nothing is counted in the
  // restart cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
    end else if (!bus.din_restart) begin
      if (overflow_hit)  overflow_cnt  <= overflow_cnt + 1'b1;
      if (underflow_hit) underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

  sd_ring_mem #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .WIDTH     (ENTRY_W)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (commit && !bus.din_restart),
    .wr_addr    (wr_ptr),
    .wr_data    (wr_data),
    .rd_addr    (rd_ptr),
    .head_data  (head_entry),
    .next_data  (next_entry),
    .wr_addr_inc(wr_ptr_inc),
    .rd_addr_inc(rd_ptr_inc)
  );

  assign bus.dout_valid     = head_valid;
  assign bus.dout_pre_valid = pre_valid;
  assign bus.dout_sd        = head_valid ? head_entry[ENTRY_W-1:CHAN_WIDTH] : '0;
  assign bus.dout_chan      = head_valid ? head_entry[CHAN_WIDTH-1:0] : '0;
  assign bus.dout_sd_pre    = pre_valid ? next_entry[ENTRY_W-1:CHAN_WIDTH] : '0;
  assign bus.din_ready      = has_space;

  assign bloc_used  = used_q;
  assign bloc_full  = used_q >= FULL_LVL;
  assign bloc_empty = used_q <= EMPTY_LVL;

endmodule

// File: tb/tb_sd_forward_mc.sv
// Self-checking bench for sd_forward_mc (DEPTH=5): a constant vector table,
// hand-written full/overflow/restart/wrap sequences, random traffic and an
// asynchronous reset mid-packet, all tracked by a queue-based reference.
module tb_sd_forward_mc;
  import sd_forward_pkg::*;

  localparam int DEPTH      = 5;
  localparam int ADDR_WIDTH = 3;
  localparam int SD_WIDTH   = 30;
  localparam int CHAN_WIDTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [ADDR_WIDTH:0] bloc_used;
  logic bloc_full, bloc_empty;
  logic [31:0] overflow_cnt, underflow_cnt;

  sd_forward_mc_if #(.SD_WIDTH(SD_WIDTH), .CHAN_WIDTH(CHAN_WIDTH)) bus ();

  sd_forward_mc #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .SD_WIDTH(SD_WIDTH),
    .CHAN_WIDTH(CHAN_WIDTH), .FULL_THRES(0), .EMPTY_THRES(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .bloc_used(bloc_used), .bloc_full(bloc_full), .bloc_empty(bloc_empty),
    .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  // Reference: committed records in FIFO order plus the in-flight packet.
  typedef struct packed {
    logic [SD_WIDTH-1:0]   sd;
    logic [CHAN_WIDTH-1:0] chan;
  } rec_t;

  rec_t        ref_q[$];
  rec_t        ref_stage;
  bit          ref_collecting, ref_discarding;
  int unsigned ref_ovf, ref_unf;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit rs, v, s, e;
    logic [SD_WIDTH-1:0] sd;
    logic [CHAN_WIDTH-1:0] ch;
    bit rdy, rep, drp;
    bit ev;
    logic [SD_WIDTH-1:0] esd;
    logic [CHAN_WIDTH-1:0] ech;
    logic [SD_WIDTH-1:0] epre;
    bit epv;
    int eused, eovf, eunf;
  } vec_t;

  vec_t tbl[18];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    ref_q.delete();
    ref_stage      = '0;
    ref_collecting = 1'b0;
    ref_discarding = 1'b0;
    ref_ovf        = 0;
    ref_unf        = 0;
  endfunction

  // One clock of the reference, from the inputs currently on the bus.
  function automatic void modelStep();
    int   used = ref_q.size();
    bit   do_commit = 1'b0;
    rec_t c = '0;
    if (bus.din_restart) begin
      ref_q.delete();
      ref_collecting = 1'b0;
      ref_discarding = 1'b0;
      return;
    end
    if (bus.din_valid && bus.din_sop) begin
      ref_collecting = 1'b0;
      ref_discarding = 1'b0;
      if (used < DEPTH) begin
        if (bus.din_eop) begin
          do_commit = 1'b1;
          c = {bus.din_sd, bus.din_chan};
        end else begin
          ref_stage = {bus.din_sd, bus.din_chan};
          ref_collecting = 1'b1;
        end
      end else if (bus.din_eop) begin
        ref_ovf++;
      end else begin
        ref_discarding = 1'b1;
      end
    end else if (bus.din_valid && bus.din_eop) begin
      if (ref_collecting) begin
        do_commit = 1'b1;
        c = ref_stage;
      end
      if (ref_discarding) ref_ovf++;
      ref_collecting = 1'b0;
      ref_discarding = 1'b0;
    end
    if (used > 0 && (bus.dout_drop || (bus.dout_ready && !bus.dout_repeat)))
      void'(ref_q.pop_front());
    else if (used == 0 && (bus.dout_ready || bus.dout_drop))
      ref_unf++;
    if (do_commit) ref_q.push_back(c);
  endfunction

  task automatic checkOutput();
    int n = ref_q.size();
    logic [SD_WIDTH-1:0]   esd  = (n > 0) ? ref_q[0].sd : '0;
    logic [CHAN_WIDTH-1:0] ech  = (n > 0) ? ref_q[0].chan : '0;
    logic [SD_WIDTH-1:0]   epre = (n > 1) ? ref_q[1].sd : '0;
    cmp("dout_valid",     32'(bus.dout_valid),     32'(n > 0));
    cmp("dout_sd",        32'(bus.dout_sd),        32'(esd));
    cmp("dout_chan",      32'(bus.dout_chan),      32'(ech));
    cmp("dout_pre_valid", 32'(bus.dout_pre_valid), 32'(n > 1));
    cmp("dout_sd_pre",    32'(bus.dout_sd_pre),    32'(epre));
    cmp("bloc_used",      32'(bloc_used),          32'(n));
    cmp("bloc_full",      32'(bloc_full),          32'(n >= DEPTH));
    cmp("bloc_empty",     32'(bloc_empty),         32'(n == 0));
    cmp("din_ready",      32'(bus.din_ready),      32'(n < DEPTH));
    cmp("overflow_cnt",   overflow_cnt,            ref_ovf);
    cmp("underflow_cnt",  underflow_cnt,           ref_unf);
  endtask

  task automatic applyStimulus(input bit rs, v, s, e,
                               input logic [SD_WIDTH-1:0] sd,
                               input logic [CHAN_WIDTH-1:0] ch,
                               input bit rdy, rep, drp);
    bus.din_restart = rs;
    bus.din_valid   = v;
    bus.din_sop     = s;
    bus.din_eop     = e;
    bus.din_sd      = sd;
    bus.din_chan    = ch;
    bus.dout_ready  = rdy;
    bus.dout_repeat = rep;
    bus.dout_drop   = drp;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    // Table: single packet, repeat/hold, ready, drop, underflow, truncation.
    tbl[0]  = '{0,1,1,0,30'h1234,2'd2,0,0,0, 0,30'h0,2'd0,30'h0,0, 0,0,0};
    tbl[1]  = '{0,1,0,0,30'h0,2'd0,0,0,0,    0,30'h0,2'd0,30'h0,0, 0,0,0};
    tbl[2]  = '{0,1,0,0,30'h0,2'd0,0,0,0,    0,30'h0,2'd0,30'h0,0, 0,0,0};
    tbl[3]  = '{0,1,0,0,30'h0,2'd0,0,0,0,    0,30'h0,2'd0,30'h0,0, 0,0,0};
    tbl[4]  = '{0,1,0,1,30'h0,2'd0,0,0,0,    1,30'h1234,2'd2,30'h0,0, 1,0,0};
    tbl[5]  = '{0,1,1,1,30'hBEEF,2'd1,0,0,0, 1,30'h1234,2'd2,30'hBEEF,1, 2,0,0};
    tbl[6]  = '{0,0,0,0,30'h0,2'd0,1,1,0,    1,30'h1234,2'd2,30'hBEEF,1, 2,0,0};
    tbl[7]  = '{0,0,0,0,30'h0,2'd0,1,1,0,    1,30'h1234,2'd2,30'hBEEF,1, 2,0,0};
    tbl[8]  = '{0,0,0,0,30'h0,2'd0,1,1,0,    1,30'h1234,2'd2,30'hBEEF,1, 2,0,0};
    tbl[9]  = '{0,0,0,0,30'h0,2'd0,1,0,0,    1,30'hBEEF,2'd1,30'h0,0, 1,0,0};
    tbl[10] = '{0,0,0,0,30'h0,2'd0,0,0,1,    0,30'h0,2'd0,30'h0,0, 0,0,0};
    tbl[11] = '{0,0,0,0,30'h0,2'd0,1,0,0,    0,30'h0,2'd0,30'h0,0, 0,0,1};
    tbl[12] = '{0,0,0,0,30'h0,2'd0,0,0,1,    0,30'h0,2'd0,30'h0,0, 0,0,2};
    tbl[13] = '{0,1,1,0,30'hAAA,2'd3,0,0,0,  0,30'h0,2'd0,30'h0,0, 0,0,2};
    tbl[14] = '{0,1,0,0,30'h0,2'd0,0,0,0,    0,30'h0,2'd0,30'h0,0, 0,0,2};
    tbl[15] = '{0,1,1,0,30'h555,2'd0,0,0,0,  0,30'h0,2'd0,30'h0,0, 0,0,2};
    tbl[16] = '{0,1,0,1,30'h0,2'd0,0,0,0,    1,30'h555,2'd0,30'h0,0, 1,0,2};
    tbl[17] = '{0,0,0,0,30'h0,2'd0,0,0,1,    0,30'h0,2'd0,30'h0,0, 0,0,2};

    // Reset.
    rst_n = 1'b0;
    bus.din_restart = 0; bus.din_valid = 0; bus.din_sop = 0; bus.din_eop = 0;
    bus.din_sd = '0; bus.din_chan = '0;
    bus.dout_ready = 0; bus.dout_repeat = 0; bus.dout_drop = 0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp("reset.din_ready",  32'(bus.din_ready), 32'd1);
    cmp("reset.bloc_empty", 32'(bloc_empty),    32'd1);
    cmp("reset.bloc_full",  32'(bloc_full),     32'd0);
    cmp("reset.dout_sd",    32'(bus.dout_sd),   32'd0);
    checkOutput();

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].rs, tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].sd, tbl[i].ch,
                    tbl[i].rdy, tbl[i].rep, tbl[i].drp);
      cmp($sformatf("tbl%0d.dout_valid", i),     32'(bus.dout_valid),     32'(tbl[i].ev));
      cmp($sformatf("tbl%0d.dout_sd", i),        32'(bus.dout_sd),        32'(tbl[i].esd));
      cmp($sformatf("tbl%0d.dout_chan", i),      32'(bus.dout_chan),      32'(tbl[i].ech));
      cmp($sformatf("tbl%0d.dout_sd_pre", i),    32'(bus.dout_sd_pre),    32'(tbl[i].epre));
      cmp($sformatf("tbl%0d.dout_pre_valid", i), 32'(bus.dout_pre_valid), 32'(tbl[i].epv));
      cmp($sformatf("tbl%0d.bloc_used", i),      32'(bloc_used),          32'(tbl[i].eused));
      cmp($sformatf("tbl%0d.overflow_cnt", i),   overflow_cnt,            32'(tbl[i].eovf));
      cmp($sformatf("tbl%0d.underflow_cnt", i),  underflow_cnt,           32'(tbl[i].eunf));
    end

    // Fill to DEPTH, then overflow by several routes.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1, 1, 0, 30'(32'h100 + i), 2'(i), 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 30'h0, 2'd0, 0, 0, 0);
    end
    cmp("fill.bloc_used", 32'(bloc_used),     32'd5);
    cmp("fill.din_ready", 32'(bus.din_ready), 32'd0);
    cmp("fill.bloc_full", 32'(bloc_full),     32'd1);
    applyStimulus(0, 1, 1, 0, 30'h999, 2'd3, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 30'h0, 2'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 30'h0, 2'd0, 0, 0, 0);
    cmp("ovf.count1",  overflow_cnt,       32'd1);
    cmp("ovf.head",    32'(bus.dout_sd),   32'h100);
    cmp("ovf.used",    32'(bloc_used),     32'd5);
    applyStimulus(0, 1, 1, 1, 30'h998, 2'd0, 0, 0, 0);
    cmp("ovf.sopeop",  overflow_cnt,       32'd2);
    applyStimulus(0, 1, 1, 0, 30'h997, 2'd0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 30'h996, 2'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 30'h0, 2'd0, 0, 0, 0);
    cmp("ovf.truncdiscard", overflow_cnt,  32'd3);
    // A pop on the sop beat of a full ring must not admit the packet.
    applyStimulus(0, 1, 1, 0, 30'h995, 2'd0, 1, 0, 0);
    cmp("ovf.popsame.used", 32'(bloc_used), 32'd4);
    cmp("ovf.popsame.head", 32'(bus.dout_sd), 32'h101);
    applyStimulus(0, 1, 0, 1, 30'h0, 2'd0, 0, 0, 0);
    cmp("ovf.popsame.count", overflow_cnt, 32'd4);
    cmp("ovf.popsame.used2", 32'(bloc_used), 32'd4);
    applyStimulus(0, 0, 0, 0, 30'h0, 2'd0, 0, 0, 1);

    // Restart with three entries and a commit and pop on the same beat.
    applyStimulus(0, 1, 1, 0, 30'h777, 2'd1, 0, 0, 0);
    cmp("restart.pre_used", 32'(bloc_used), 32'd3);
    applyStimulus(1, 1, 0, 1, 30'h0, 2'd0, 1, 0, 0);
    cmp("restart.used",  32'(bloc_used),      32'd0);
    cmp("restart.valid", 32'(bus.dout_valid), 32'd0);
    cmp("restart.ovf",   overflow_cnt,        32'd4);
    cmp("restart.unf",   underflow_cnt,       32'd2);
    applyStimulus(0, 1, 1, 1, 30'h321, 2'd1, 0, 0, 0);
    cmp("restart.after", 32'(bus.dout_sd), 32'h321);

    // Wrap the ring with a commit and a pop on the same beat each packet.
    applyStimulus(0, 1, 1, 1, 30'h322, 2'd2, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 1, 0, 30'(32'h200 + i), 2'(i), 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 30'h0, 2'd0, 1, 0, 0);
      cmp($sformatf("wrap%0d.used", i), 32'(bloc_used), 32'd2);
    end
    applyStimulus(0, 0, 0, 0, 30'h0, 2'd0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 30'h0, 2'd0, 0, 0, 1);

    // Random traffic against the reference.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) < 3,
                    30'($urandom), 2'($urandom),
                    $urandom_range(0, 9) < 4,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset in the middle of an accepted packet.
    applyStimulus(0, 1, 1, 0, 30'h4242, 2'd2, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    cmp("areset.used",      32'(bloc_used),      32'd0);
    cmp("areset.valid",     32'(bus.dout_valid), 32'd0);
    cmp("areset.ovf",       overflow_cnt,        32'd0);
    cmp("areset.din_ready", 32'(bus.din_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 1, 30'h0, 2'd0, 0, 0, 0);
    cmp("areset.lost", 32'(bloc_used), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_forward_mc.md
Name: sd_forward_mc

Overview:
- Single-clock, parametrised successor to the sideband store-and-forward block.
- Captures one sideband record per input packet, tagged with a channel index, into a DEPTH-entry ring.
- Commits the record only when the packet completes and presents the head and next (predictive) records to the downstream framer.
- Adds packet-level commit/abort, configurable depth and width, drop/repeat read modes, and overflow/underflow statistics.

Parameters:
- DEPTH, 5: ring entries; any value ≥ 2, not necessarily a power of two.
- ADDR_WIDTH, 3: pointer width; must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- SD_WIDTH, 30: sideband record width; default layout is sd_field_t.
- CHAN_WIDTH, 2: channel tag width.
- FULL_THRES, 0: bloc_full asserts when used ≥ DEPTH-FULL_THRES.
- EMPTY_THRES, 0: bloc_empty asserts when used ≤ EMPTY_THRES.

Ports:
- clk, in, 1: clock, posedge active.
- rst_n, in, 1: reset; asynchronous, active-low.
- din_restart, in, 1: synchronous flush of ring and FSM.
- din_valid, in, 1: input beat valid.
- din_sop, in, 1: input start of packet.
- din_eop, in, 1: input end of packet.
- din_sd, in, SD_WIDTH: sideband record, sampled on sop beat.
- din_chan, in, CHAN_WIDTH: channel tag, sampled on sop beat.
- dout_ready, in, 1: consume head.
- dout_repeat, in, 1: with dout_ready, retain head (hold mode).
- dout_drop, in, 1: discard head without consuming as output.
- din_ready, out, 1: space available for a new packet.
- dout_valid, out, 1: head record present.
- dout_sd, out, SD_WIDTH: head record.
- dout_chan, out, CHAN_WIDTH: head channel tag.
- dout_sd_pre, out, SD_WIDTH: next record after head.
- dout_pre_valid, out, 1: next record present.
- bloc_used, out, ADDR_WIDTH+1: committed entry count, 0..DEPTH.
- bloc_full, out, 1: threshold full flag.
- bloc_empty, out, 1: threshold empty flag.
- overflow_cnt, out, 32: packets discarded for lack of space.
- underflow_cnt, out, 32: pops or drops issued while empty.

Behaviour:
- Reset: pointers, bloc_used, FSM, both counters and storage clear to 0.
  - Outputs at reset: dout_valid=0, dout_pre_valid=0, dout_sd=0, dout_sd_pre=0, dout_chan=0, bloc_empty=1, bloc_full=0, din_ready=1.
- Write FSM states: IDLE, ACCEPT, DISCARD.
  - IDLE: on din_valid&din_sop with used<DEPTH, latch din_sd/din_chan into the staging register and go to ACCEPT.
  - IDLE: on din_valid&din_sop with used==DEPTH, go to DISCARD.
  - Non-sop beats in IDLE are ignored.
- Commit: on din_valid&din_eop in ACCEPT, or on the sop beat itself if sop&eop, the staged record is written at wr_ptr. wr_ptr advances and the FSM returns to IDLE.
  - Record is visible at dout one cycle after the eop beat; bloc_used is registered.
- Discard: din_valid&din_eop in DISCARD increments overflow_cnt (wraps at 2^32) and returns to IDLE.
  - sop&eop on the same beat while full increments overflow_cnt in that cycle and stays IDLE.
- Truncated packet: din_valid&din_sop while in ACCEPT or DISCARD aborts the current packet with no commit and no count. The new sop is re-evaluated as if in IDLE, in the same cycle.
- Space check uses the registered used count at the sop beat. A pop in the same cycle does not make room.
- din_ready = (used<DEPTH). It is advisory; the FSM enforces admission.
- Pointer wrap: ptr==DEPTH-1 advances to 0.
- dout_sd / dout_chan / dout_sd_pre are combinational from storage at rd_ptr and rd_ptr+1 (wrapped). Each is gated to 0 when its valid is low.
- dout_valid = used≥1; dout_pre_valid = used≥2.
- Read actions, priority drop > ready:
  - dout_drop & dout_valid: rd_ptr advances, used decrements.
  - dout_ready & dout_valid & !dout_repeat: same as drop.
  - dout_ready & dout_repeat: no pointer change; head is held.
  - dout_ready or dout_drop with used==0: underflow_cnt increments; no pointer change.
- Simultaneous commit and release: used unchanged; both pointers advance.
- Commit at used==DEPTH cannot occur, because admission was checked at sop.
- din_restart: wr_ptr, rd_ptr and used go to 0 and FSM goes to IDLE next cycle. It overrides a same-cycle commit and pop. Counters and storage are retained.
- Asynchronous reset mid-packet: state as after reset; the partial packet is lost and not counted.

Decomposition:
- Package sd_forward_pkg:
  - sd_field_t packed struct: ante[1:0], exp[5:0], symbol[3:0], slot[7:0], frame[9:0] (30 bits).
  - wr_state_e enum: IDLE, ACCEPT, DISCARD.
  - CNT_WIDTH=32.
- Sub-module sd_ring_mem: DEPTH×(SD_WIDTH+CHAN_WIDTH) register array.
  - Write port.
  - Two combinational read ports (head, next).
  - Wrapped-increment helper.
- FSM, occupancy and counters live in the top level.

Test Plan:
- DEPTH=5: packet sop(sd=0x1234,chan=2)…eop 4 beats later → dout_valid rises the cycle after eop; dout_sd=0x1234, dout_chan=2, bloc_used=1; dout_pre_valid=0.
- Commit 5 packets, then a 6th → bloc_used=5, din_ready=0; 6th eop sets overflow_cnt=1; dout_sd still holds the 1st record.
- With 2 entries (A, B): dout_ready&dout_repeat for 3 cycles → dout_sd stays A, used=2. Then dout_ready alone → dout_sd=B, used=1. Then dout_drop → used=0, dout_valid=0.
- sop(sd=X), no eop, then a new sop(sd=Y)…eop → only Y is committed; used=1; overflow_cnt unchanged.
- Ring full-cycle wrap with DEPTH=5 over 12 packets, interleaving a commit and a pop in the same cycle → FIFO order is preserved; used is constant across the simultaneous cycle; dout_sd_pre always equals the following record.
- dout_ready at used=0 → underflow_cnt=1. Then din_restart with 3 entries and a commit on the same cycle → used=0 next cycle; counters are retained.
